// File: rtl/ysyx_24110006_arbiter.sv
// ysyx_24110006_arbiter: two AXI read masters (m0 = IFU, m1 = LSU) sharing one slave.
// A transaction owns the slave from its AR handshake until the last R beat; one
// IDLE cycle always separates two transactions.
// Build option: define CONFIG_ARB_RR_EN for round-robin arbitration; left
// undefined, arbitration is fixed priority with m1 winning ties.
module ysyx_24110006_arbiter (
    input  logic        i_clock,
    input  logic        i_reset,

    // master 0 (IFU)
    input  logic [31:0] i_m0_axi_araddr,
    input  logic        i_m0_axi_arvalid,
    input  logic [3:0]  i_m0_axi_arid,
    input  logic [7:0]  i_m0_axi_arlen,
    input  logic [2:0]  i_m0_axi_arsize,
    input  logic [1:0]  i_m0_axi_arburst,
    output logic        o_m0_axi_arready,
    output logic [31:0] o_m0_axi_rdata,
    output logic        o_m0_axi_rvalid,
    output logic [1:0]  o_m0_axi_rresp,
    output logic [3:0]  o_m0_axi_rid,
    output logic        o_m0_axi_rlast,
    input  logic        i_m0_axi_rready,

    // master 1 (LSU)
    input  logic [31:0] i_m1_axi_araddr,
    input  logic        i_m1_axi_arvalid,
    input  logic [3:0]  i_m1_axi_arid,
    input  logic [7:0]  i_m1_axi_arlen,
    input  logic [2:0]  i_m1_axi_arsize,
    input  logic [1:0]  i_m1_axi_arburst,
    output logic        o_m1_axi_arready,
    output logic [31:0] o_m1_axi_rdata,
    output logic        o_m1_axi_rvalid,
    output logic [1:0]  o_m1_axi_rresp,
    output logic [3:0]  o_m1_axi_rid,
    output logic        o_m1_axi_rlast,
    input  logic        i_m1_axi_rready,

    // slave side
    output logic [31:0] o_axi_araddr,
    output logic        o_axi_arvalid,
    output logic [3:0]  o_axi_arid,
    output logic [7:0]  o_axi_arlen,
    output logic [2:0]  o_axi_arsize,
    output logic [1:0]  o_axi_arburst,
    input  logic        i_axi_arready,
    input  logic [31:0] i_axi_rdata,
    input  logic        i_axi_rvalid,
    input  logic [1:0]  i_axi_rresp,
    input  logic [3:0]  i_axi_rid,
    input  logic        i_axi_rlast,
    output logic        o_axi_rready,

    output logic [1:0]  o_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e     state_q;
    logic [1:0] grant_q;
    logic [1:0] win_d;
    logic       in_addr;
    logic       in_data;
    logic       ar_hs;
    logic       r_last_hs;

`ifdef CONFIG_ARB_RR_EN
    // Set when m1 received the most recent grant; reset value favours m0 first.
    logic       last_m1_q;
`endif

    assign in_addr   = (state_q == ADDR);
    assign in_data   = (state_q == DATA);
    assign ar_hs     = o_axi_arvalid && i_axi_arready;
    assign r_last_hs = i_axi_rvalid && o_axi_rready && i_axi_rlast;
    assign o_grant   = grant_q;

    // Pick the winner among the current requesters (only consumed in IDLE).
    always_comb begin
        win_d = '0;
`ifdef CONFIG_ARB_RR_EN
        if (i_m0_axi_arvalid && i_m1_axi_arvalid) begin
            win_d = last_m1_q ? 2'b01 : 2'b10;
        end else begin
            win_d = {i_m1_axi_arvalid, i_m0_axi_arvalid};
        end
`else
        if (i_m1_axi_arvalid) begin
            win_d = 2'b10;
        end else if (i_m0_axi_arvalid) begin
            win_d = 2'b01;
        end
`endif
    end

    // Ownership FSM: grant in IDLE, hold through address and data phases.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
`ifdef CONFIG_ARB_RR_EN
            last_m1_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_m0_axi_arvalid || i_m1_axi_arvalid) begin
                        grant_q   <= win_d;
                        state_q   <= ADDR;
`ifdef CONFIG_ARB_RR_EN
                        last_m1_q <= win_d[1];
`endif
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (r_last_hs) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Route the granted master's AR channel to the slave; valid only in ADDR.
    always_comb begin
        o_axi_araddr  = '0;
        o_axi_arid    = '0;
        o_axi_arlen   = '0;
        o_axi_arsize  = '0;
        o_axi_arburst = '0;
        o_axi_arvalid = 1'b0;
        if (grant_q[1]) begin
            o_axi_araddr  = i_m1_axi_araddr;
            o_axi_arid    = i_m1_axi_arid;
            o_axi_arlen   = i_m1_axi_arlen;
            o_axi_arsize  = i_m1_axi_arsize;
            o_axi_arburst = i_m1_axi_arburst;
            o_axi_arvalid = in_addr && i_m1_axi_arvalid;
        end else if (grant_q[0]) begin
            o_axi_araddr  = i_m0_axi_araddr;
            o_axi_arid    = i_m0_axi_arid;
            o_axi_arlen   = i_m0_axi_arlen;
            o_axi_arsize  = i_m0_axi_arsize;
            o_axi_arburst = i_m0_axi_arburst;
            o_axi_arvalid = in_addr && i_m0_axi_arvalid;
        end
    end

    // Handshake steering: only the owner sees arready/rvalid, only its rready reaches the slave.
    always_comb begin
        o_m0_axi_arready = in_addr && grant_q[0] && i_axi_arready;
        o_m1_axi_arready = in_addr && grant_q[1] && i_axi_arready;
        o_m0_axi_rvalid  = in_data && grant_q[0] && i_axi_rvalid;
        o_m1_axi_rvalid  = in_data && grant_q[1] && i_axi_rvalid;
        o_axi_rready     = in_data && ((grant_q[0] && i_m0_axi_rready) ||
                                       (grant_q[1] && i_m1_axi_rready));
    end

    // R payload is broadcast; the per-master rvalid decides who consumes it.
    always_comb begin
        o_m0_axi_rdata = i_axi_rdata;
        o_m0_axi_rresp = i_axi_rresp;
        o_m0_axi_rid   = i_axi_rid;
        o_m0_axi_rlast = i_axi_rlast;
        o_m1_axi_rdata = i_axi_rdata;
        o_m1_axi_rresp = i_axi_rresp;
        o_m1_axi_rid   = i_axi_rid;
        o_m1_axi_rlast = i_axi_rlast;
    end

endmodule

// File: tb/tb_ysyx_24110006_arbiter.sv
// Bench for ysyx_24110006_arbiter: directed scenarios plus randomized traffic,
// expectations from a transaction-level model of the arbitration rules.
// Compile with the same CONFIG_ARB_RR_EN setting as the design.
module tb_ysyx_24110006_arbiter;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;

    logic [31:0] ar_addr  [2];
    logic        ar_valid [2];
    logic [3:0]  ar_id    [2];
    logic [7:0]  ar_len   [2];
    logic [2:0]  ar_size  [2];
    logic [1:0]  ar_burst [2];
    logic        r_ready  [2];
    logic        m_arready[2];
    logic [31:0] m_rdata  [2];
    logic        m_rvalid [2];
    logic [1:0]  m_rresp  [2];
    logic [3:0]  m_rid    [2];
    logic        m_rlast  [2];

    logic [31:0] o_axi_araddr;
    logic        o_axi_arvalid;
    logic [3:0]  o_axi_arid;
    logic [7:0]  o_axi_arlen;
    logic [2:0]  o_axi_arsize;
    logic [1:0]  o_axi_arburst;
    logic        i_axi_arready;
    logic [31:0] i_axi_rdata;
    logic        i_axi_rvalid;
    logic [1:0]  i_axi_rresp;
    logic [3:0]  i_axi_rid;
    logic        i_axi_rlast;
    logic        o_axi_rready;
    logic [1:0]  o_grant;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned fails  = 0;
    int          last_gnt;   // model: master granted most recently (1 after reset)

    ysyx_24110006_arbiter u_dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_m0_axi_araddr  (ar_addr[0]),
        .i_m0_axi_arvalid (ar_valid[0]),
        .i_m0_axi_arid    (ar_id[0]),
        .i_m0_axi_arlen   (ar_len[0]),
        .i_m0_axi_arsize  (ar_size[0]),
        .i_m0_axi_arburst (ar_burst[0]),
        .o_m0_axi_arready (m_arready[0]),
        .o_m0_axi_rdata   (m_rdata[0]),
        .o_m0_axi_rvalid  (m_rvalid[0]),
        .o_m0_axi_rresp   (m_rresp[0]),
        .o_m0_axi_rid     (m_rid[0]),
        .o_m0_axi_rlast   (m_rlast[0]),
        .i_m0_axi_rready  (r_ready[0]),
        .i_m1_axi_araddr  (ar_addr[1]),
        .i_m1_axi_arvalid (ar_valid[1]),
        .i_m1_axi_arid    (ar_id[1]),
        .i_m1_axi_arlen   (ar_len[1]),
        .i_m1_axi_arsize  (ar_size[1]),
        .i_m1_axi_arburst (ar_burst[1]),
        .o_m1_axi_arready (m_arready[1]),
        .o_m1_axi_rdata   (m_rdata[1]),
        .o_m1_axi_rvalid  (m_rvalid[1]),
        .o_m1_axi_rresp   (m_rresp[1]),
        .o_m1_axi_rid     (m_rid[1]),
        .o_m1_axi_rlast   (m_rlast[1]),
        .i_m1_axi_rready  (r_ready[1]),
        .o_axi_araddr     (o_axi_araddr),
        .o_axi_arvalid    (o_axi_arvalid),
        .o_axi_arid       (o_axi_arid),
        .o_axi_arlen      (o_axi_arlen),
        .o_axi_arsize     (o_axi_arsize),
        .o_axi_arburst    (o_axi_arburst),
        .i_axi_arready    (i_axi_arready),
        .i_axi_rdata      (i_axi_rdata),
        .i_axi_rvalid     (i_axi_rvalid),
        .i_axi_rresp      (i_axi_rresp),
        .i_axi_rid        (i_axi_rid),
        .i_axi_rlast      (i_axi_rlast),
        .o_axi_rready     (o_axi_rready),
        .o_grant          (o_grant)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clock);
        #1;
    endtask

    // Arbitration rule: a lone requester wins; ties go by policy.
    function automatic int pick(input bit r0, input bit r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef CONFIG_ARB_RR_EN
        return (last_gnt == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    // Raise requests in IDLE, advance one edge, check who got the grant.
    task automatic start_txn(input bit r0, input bit r1, input int flen, output int w);
        bit r[2];
        r[0] = r0 | ar_valid[0];
        r[1] = r1 | ar_valid[1];
        for (int i = 0; i < 2; i++) begin
            if (r[i] && !ar_valid[i]) begin
                ar_addr[i]  = $urandom;
                ar_id[i]    = 4'($urandom_range(15, 0));
                ar_len[i]   = (flen >= 0) ? 8'(flen) : 8'($urandom_range(3, 0));
                ar_size[i]  = 3'($urandom_range(7, 0));
                ar_burst[i] = 2'($urandom_range(3, 0));
                ar_valid[i] = 1'b1;
            end
        end
        #1;
        chk("idle_arvalid", o_axi_arvalid, 0);
        chk("idle_grant", o_grant, 0);
        tick;
        w = pick(r[0], r[1]);
        chk("grant", o_grant, 64'(2'b01 << w));
        last_gnt = w;
    endtask

    // Address phase for owner w; slave accepts after `delay` wait cycles.
    task automatic addr_phase(input int w, input int delay);
        for (int k = 0; k <= delay; k++) begin
            i_axi_arready = (k == delay);
            i_axi_rvalid  = 1'($urandom_range(1, 0));
            #1;
            chk("addr_arvalid", o_axi_arvalid, 1);
            chk("addr_fields",
                {o_axi_arid, o_axi_arlen, o_axi_arsize, o_axi_arburst, o_axi_araddr},
                {ar_id[w], ar_len[w], ar_size[w], ar_burst[w], ar_addr[w]});
            chk("addr_arready_own", m_arready[w], i_axi_arready);
            chk("addr_arready_other", m_arready[1-w], 0);
            chk("addr_rready", o_axi_rready, 0);
            chk("addr_rvalid_own", m_rvalid[w], 0);
            tick;
        end
        ar_valid[w]   = 1'b0;
        i_axi_arready = 1'b0;
        i_axi_rvalid  = 1'b0;
    endtask

    // Data phase: slave model streams len+1 beats; rst_beat >= 0 aborts by reset there.
    task automatic data_phase(input int w, input int len, input bit gaps, input bit stalls,
                              input bit err0, input bit use_d0, input logic [31:0] d0,
                              input int rst_beat);
        logic [31:0] exp_q[$];
        int b   = 0;
        int cyc = 0;
        for (int i = 0; i <= len; i++) exp_q.push_back((i == 0 && use_d0) ? d0 : $urandom);
        while (b <= len && cyc < 200) begin
            cyc++;
            i_axi_rvalid  = gaps ? ($urandom_range(2, 0) != 0) : 1'b1;
            r_ready[w]    = stalls ? ($urandom_range(2, 0) != 0) : 1'b1;
            r_ready[1-w]  = 1'($urandom_range(1, 0));
            i_axi_rdata   = i_axi_rvalid ? exp_q[b] : $urandom;
            i_axi_rresp   = (err0 && b == 0) ? 2'b10 : 2'($urandom_range(1, 0));
            i_axi_rid     = 4'($urandom_range(15, 0));
            i_axi_rlast   = (b == len);
            #1;
            chk("data_rvalid_own", m_rvalid[w], i_axi_rvalid);
            chk("data_rvalid_other", m_rvalid[1-w], 0);
            chk("data_rready", o_axi_rready, r_ready[w]);
            chk("data_arvalid", o_axi_arvalid, 0);
            chk("data_arready_other", m_arready[1-w], 0);
            chk("bcast_m0", {m_rdata[0], m_rresp[0], m_rid[0], m_rlast[0]},
                {i_axi_rdata, i_axi_rresp, i_axi_rid, i_axi_rlast});
            chk("bcast_m1", {m_rdata[1], m_rresp[1], m_rid[1], m_rlast[1]},
                {i_axi_rdata, i_axi_rresp, i_axi_rid, i_axi_rlast});
            if (rst_beat == b && i_axi_rvalid) begin
                i_reset = 1'b0;
                #1;
                chk("rst_grant", o_grant, 0);
                chk("rst_rready", o_axi_rready, 0);
                chk("rst_rvalid", m_rvalid[w], 0);
                chk("rst_arvalid", o_axi_arvalid, 0);
                ar_valid[0] = 1'b0;
                ar_valid[1] = 1'b0;
                last_gnt    = 1;
                #1;
                i_reset = 1'b1;
                tick;
                chk("post_rst_rvalid", m_rvalid[w], 0);
                chk("post_rst_rready", o_axi_rready, 0);
                chk("post_rst_grant", o_grant, 0);
                i_axi_rvalid = 1'b0;
                r_ready[0]   = 1'b0;
                r_ready[1]   = 1'b0;
                return;
            end
            if (i_axi_rvalid && r_ready[w]) begin
                if (err0 && b == 0) chk("err_resp", m_rresp[w], 2'b10);
                chk("beat_data", m_rdata[w], exp_q[b]);
                b++;
            end
            tick;
            if (b <= len) chk("hold_grant", o_grant, 64'(2'b01 << w));
        end
        chk("beat_count", b, len + 1);
        i_axi_rvalid = 1'b0;
        r_ready[0]   = 1'b0;
        r_ready[1]   = 1'b0;
        chk("end_grant", o_grant, 0);
        chk("end_rready", o_axi_rready, 0);
        chk("end_arvalid", o_axi_arvalid, 0);
    endtask

    task automatic full_txn(input bit r0, input bit r1, input int flen, output int w);
        start_txn(r0, r1, flen, w);
        addr_phase(w, $urandom_range(2, 0));
        data_phase(w, int'(ar_len[w]), 1'b1, 1'b1, 1'b0, 1'b0, '0, -1);
    endtask

    initial begin
        int w;
        int e032[2];
`ifdef CONFIG_ARB_RR_EN
        e032 = '{0, 1};
`else
        e032 = '{1, 0};
`endif
        last_gnt = 1;
        for (int i = 0; i < 2; i++) begin
            ar_addr[i] = '0; ar_valid[i] = 1'b0; ar_id[i] = '0; ar_len[i] = '0;
            ar_size[i] = '0; ar_burst[i] = '0; r_ready[i] = 1'b0;
        end
        i_axi_arready = 1'b0; i_axi_rdata = '0; i_axi_rvalid = 1'b0;
        i_axi_rresp = '0; i_axi_rid = '0; i_axi_rlast = 1'b0;

        // Reset state, with a request and slave rvalid pending.
        ar_valid[0]  = 1'b1;
        i_axi_rvalid = 1'b1;
        r_ready[0]   = 1'b1;
        #3;
        chk("reset_grant", o_grant, 0);
        chk("reset_arvalid", o_axi_arvalid, 0);
        chk("reset_rready", o_axi_rready, 0);
        chk("reset_ready_valid", {m_arready[0], m_arready[1], m_rvalid[0], m_rvalid[1]}, 0);
        tick;
        tick;
        chk("reset_hold_grant", o_grant, 0);
        i_reset = 1'b1;
        #1;
        chk("release_no_grant", o_grant, 0);
        ar_valid[0]  = 1'b0;
        i_axi_rvalid = 1'b0;
        r_ready[0]   = 1'b0;
        tick;
        chk("release_idle", o_grant, 0);

        // m0 alone, single beat 0xDEADBEEF from 0x3000_0000.
        ar_addr[0] = 32'h3000_0000; ar_id[0] = 4'h3; ar_len[0] = 8'd0;
        ar_size[0] = 3'd2; ar_burst[0] = 2'b01; ar_valid[0] = 1'b1;
        start_txn(1'b1, 1'b0, 0, w);
        chk("m0_alone_addr", o_axi_araddr, 32'h3000_0000);
        addr_phase(w, 0);
        data_phase(w, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, -1);

        // m0 len 3 with gaps/stalls while m1 waits; m1 served next.
        start_txn(1'b1, 1'b0, 3, w);
        chk("burst_owner", w, 0);
        ar_addr[1] = $urandom; ar_len[1] = 8'd1; ar_id[1] = 4'h9;
        ar_size[1] = 3'd2; ar_burst[1] = 2'b01; ar_valid[1] = 1'b1;
        addr_phase(w, 2);
        data_phase(w, 3, 1'b1, 1'b1, 1'b0, 1'b0, '0, -1);
        start_txn(1'b0, 1'b1, -1, w);
        chk("held_m1_served", w, 1);
        addr_phase(w, 1);
        data_phase(w, int'(ar_len[w]), 1'b1, 1'b0, 1'b0, 1'b0, '0, -1);

        // SLVERR on first beat of a two-beat burst keeps the burst going.
        start_txn(1'b1, 1'b0, 1, w);
        addr_phase(w, 0);
        data_phase(w, 1, 1'b0, 1'b0, 1'b1, 1'b0, '0, -1);

        // Reset during beat 2 of 4.
        start_txn(1'b1, 1'b0, 3, w);
        addr_phase(w, 0);
        data_phase(w, 3, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1);

        // Simultaneous requests straight after reset.
        start_txn(1'b1, 1'b1, -1, w);
        chk("tie_first", w, e032[0]);
        addr_phase(w, 0);
        data_phase(w, int'(ar_len[w]), 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);
        start_txn(1'b0, 1'b0, -1, w);
        chk("tie_second", w, e032[1]);
        addr_phase(w, 0);
        data_phase(w, int'(ar_len[w]), 1'b0, 1'b0, 1'b0, 1'b0, '0, -1);

        // Both masters requesting continuously for six transactions.
        for (int i = 0; i < 6; i++) begin
            full_txn(1'b1, 1'b1, -1, w);
`ifdef CONFIG_ARB_RR_EN
            chk("continuous_order", w, i % 2);
`else
            chk("continuous_order", w, 1);
`endif
        end

        // Randomized traffic.
        for (int i = 0; i < 20; i++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(1, 0));
            r1 = 1'($urandom_range(1, 0));
            if (!r0 && !r1 && !ar_valid[0] && !ar_valid[1]) r0 = 1'b1;
            full_txn(r0, r1, -1, w);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ysyx_24110006_arbiter.md
YSYX_24110006_ARBITER -- requirements
Module: ysyx_24110006_arbiter

Interface
REQ-001 SHALL have no parameters; address/data width fixed 32, ID 4, LEN 8, SIZE 3, BURST 2, RESP 2.
REQ-002 SHALL have port i_clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have bundle i_m0_axi_ar{addr,valid,id,len,size,burst}  input  32/1/4/8/3/2  master 0 (IFU) read address.
REQ-005 SHALL have port o_m0_axi_arready  output  1  master 0 AR accept.
REQ-006 SHALL have bundle o_m0_axi_r{data,valid,resp,id,last}  output  32/1/2/4/1  master 0 read data; i_m0_axi_rready  input  1.
REQ-007 SHALL have bundles i_m1_axi_ar*, o_m1_axi_arready, o_m1_axi_r*, i_m1_axi_rready, identical widths, master 1 (LSU).
REQ-008 SHALL have bundle o_axi_ar{addr,valid,id,len,size,burst}  output  32/1/4/8/3/2  and i_axi_arready  input  1  to the slave.
REQ-009 SHALL have bundle i_axi_r{data,valid,resp,id,last}  input  32/1/2/4/1  and o_axi_rready  output  1  from the slave.
REQ-010 SHALL have port o_grant  output  2  one-hot current owner (bit0 m0, bit1 m1), 00 when idle.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-012 IDLE: if any master arvalid, SHALL register the winner into o_grant and go to ADDR next cycle; else stay IDLE.
REQ-013 Latency: master arvalid rising in IDLE at cycle N SHALL produce o_axi_arvalid at cycle N+1.
REQ-014 ADDR: o_axi_ar* SHALL equal the granted master's ar* fields; granted arready = i_axi_arready; ungranted arready = 0.
REQ-015 ADDR: on o_axi_arvalid && i_axi_arready SHALL go to DATA; o_axi_arvalid SHALL be 0 in IDLE and DATA.
REQ-016 DATA: granted r-valid = i_axi_rvalid, o_axi_rready = granted rready; ungranted rvalid = 0.
REQ-017 r{data,resp,id,last} SHALL be broadcast unmodified to both masters in all states.
REQ-018 DATA: on i_axi_rvalid && o_axi_rready && i_axi_rlast SHALL return to IDLE and clear o_grant; beats without rlast keep DATA.
REQ-019 SHALL insert exactly one IDLE cycle between transactions (no same-cycle re-grant).
REQ-020 Grant SHALL be locked from ADDR until the last-beat handshake; requests from the other master are held off, never dropped.
REQ-021 rresp SLVERR/DECERR SHALL NOT shorten the transaction; termination only on rlast.
REQ-022 o_axi_rready SHALL be 0 in IDLE and ADDR; i_axi_rvalid outside DATA is ignored.
REQ-023 A master deasserting arvalid in ADDR is a protocol violation; behaviour unspecified, no recovery required.

Reset
REQ-024 i_reset low SHALL asynchronously force IDLE, o_grant=00, all arvalid/arready/rvalid/rready outputs 0, RR pointer = m1.
REQ-025 Reset mid-transaction SHALL abandon the burst; no further beats forwarded after reset release until a new grant.
REQ-026 First grant after reset release SHALL occur no earlier than the first rising edge with i_reset high.

Configuration
REQ-027 Macro CONFIG_ARB_RR_EN SHALL select arbitration policy.
REQ-028 Defined: round-robin; on simultaneous requests the master not granted last wins; pointer updates on each grant.
REQ-029 Undefined: fixed priority, m1 (LSU) always wins ties; no pointer state exists.
REQ-030 Single requester SHALL be granted immediately under both policies.

Verification
REQ-031 m0 alone, araddr 0x3000_0000 len 0 -> o_axi_arvalid at N+1 with addr 0x3000_0000, one beat 0xDEADBEEF to m0, o_grant 01 then 00.
REQ-032 Both request same cycle, macro undefined -> m1 first, m0 second, one IDLE cycle between; macro defined -> m0 first, then m1.
REQ-033 m0 burst len 3 with slave rvalid gaps and m0 rready stalls -> 4 beats delivered in order, m1 arready held 0 throughout.
REQ-034 Slave returns rresp=2'b10 on beat 1 of len 1 -> resp forwarded, FSM stays DATA until rlast beat.
REQ-035 Assert i_reset low during DATA beat 2 of 4 -> outputs 0 asynchronously, o_grant 00, post-release stale rvalid not forwarded.
REQ-036 RR defined, both masters request continuously 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1.
